// File: rtl/uart_pkg.sv
// Shared UART definitions: parity_mode encodings, transmitter state type and parity helpers.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Encoding 2'b11 is reserved and behaves like PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode != PAR_NONE) && (mode != (PAR_ODD | PAR_EVEN));
  endfunction

  // Zero-extended upper bits leave the XOR unchanged, so any word width up to 9 fits.
  function automatic logic parity_bit(input logic [8:0] word, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~(^word) : (^word);
  endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits, runtime parity and stop bits, back-to-back frames.
// Define UART_TX_CFG_BREAK_EN to add the break_req input (line break while idle).
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 baud_strobe,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
`ifdef UART_TX_CFG_BREAK_EN
  input  logic                 break_req,
`endif
  output logic                 txd,
  output logic                 busy
);

  localparam int unsigned    TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]  TICK_MAX  = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);

  tx_state_t              r_state;
  tx_state_t              w_next;
  logic [TW-1:0]          r_tick_cnt;
  logic [3:0]             r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_bit;
  logic                   r_par_en;
  logic                   r_stop2;
  logic                   r_txd;
  logic                   r_busy;
  logic                   w_tick;
  logic                   w_bit_end;
  logic                   w_last_stop;
  logic                   w_accept;
  logic                   w_brk_idle;
  logic                   w_brk_block;

  assign w_tick      = clken & baud_strobe;
  assign w_bit_end   = w_tick && (r_tick_cnt == '0);
  assign w_last_stop = (r_state == STOP) && (r_bit_cnt == '0);

`ifdef UART_TX_CFG_BREAK_EN
  logic r_brk_hold;

  assign w_brk_idle  = break_req && (r_state == IDLE);
  // A request seen at the end of a frame suppresses the chained start, so the line drops to IDLE first.
  assign w_brk_block = break_req || r_brk_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_brk_hold <= 1'b0;
    end else if (clken) begin
      if (w_brk_idle) begin
        r_brk_hold <= 1'b1;
      end else if (r_brk_hold && w_bit_end) begin
        r_brk_hold <= 1'b0;
      end
    end
  end
`else
  assign w_brk_idle  = 1'b0;
  assign w_brk_block = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (clken) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = START;
      START:   if (w_bit_end) w_next = DATA;
      DATA:    if (w_bit_end && (r_bit_cnt == '0)) w_next = r_par_en ? PARITY : STOP;
      PARITY:  if (w_bit_end) w_next = STOP;
      STOP: begin
        if (w_accept) begin
          w_next = START;
        end else if (w_bit_end && (r_bit_cnt == '0)) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ready    = w_tick && !w_brk_block &&
               ((r_state == IDLE) || (w_last_stop && (r_tick_cnt == '0)));
    w_accept = ready && valid;
    txd      = r_txd && !w_brk_idle;
    busy     = r_busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
    end else if (clken) begin
      if (w_accept) begin
        r_shift    <= data;
        r_par_bit  <= parity_bit(9'(data), parity_mode);
        r_par_en   <= parity_enabled(parity_mode);
        r_stop2    <= stop2;
        r_txd      <= 1'b0;
        r_tick_cnt <= TICK_MAX;
        r_busy     <= 1'b1;
      end else if (w_bit_end && (r_state != IDLE)) begin
        r_tick_cnt <= TICK_MAX;
        case (r_state)
          START: begin
            r_txd     <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= LAST_DATA;
          end
          DATA: begin
            if (r_bit_cnt != '0) begin
              r_txd     <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt - 4'd1;
            end else if (r_par_en) begin
              r_txd <= r_par_bit;
            end else begin
              r_txd     <= 1'b1;
              r_bit_cnt <= {3'b000, r_stop2};
            end
          end
          PARITY: begin
            r_txd     <= 1'b1;
            r_bit_cnt <= {3'b000, r_stop2};
          end
          STOP: begin
            if (r_bit_cnt != '0) begin
              r_bit_cnt <= r_bit_cnt - 4'd1;
            end else begin
              r_busy     <= 1'b0;
              r_tick_cnt <= '0;
            end
          end
          default: r_txd <= 1'b1;
        endcase
      end else if (w_tick && (r_tick_cnt != '0)) begin
        r_tick_cnt <= r_tick_cnt - TW'(1);
      end
`ifdef UART_TX_CFG_BREAK_EN
      // The tick counter doubles as the post-break mark timer while idle.
      if (w_brk_idle) begin
        r_tick_cnt <= TICK_MAX;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: vector table, hand-written corner sequences and random frames
// checked tick by tick against a frame-level reference model.
module tb_uart_tx_cfg;

  localparam int OS = 4;

  typedef struct {
    bit         sel;       // 0: 8-bit instance, 1: 5-bit instance
    logic [8:0] data;
    logic [1:0] pm;
    logic       s2;
    bit         scramble;  // change inputs right after acceptance
    int         exp_len;   // frame length in ticks
    int         exp_par;   // expected parity bit, -1 when no parity bit
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, clken, baud_strobe;
  logic [7:0] data8;
  logic [1:0] pm8;
  logic       valid8, s2_8, ready8, txd8, busy8;
  logic [4:0] data5;
  logic [1:0] pm5;
  logic       valid5, s2_5, ready5, txd5, busy5;
`ifdef UART_TX_CFG_BREAK_EN
  logic       brk8, brk5;
`endif

  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut8 (
    .clk(clk), .rst(rst), .clken(clken), .baud_strobe(baud_strobe),
    .data(data8), .valid(valid8), .ready(ready8), .parity_mode(pm8), .stop2(s2_8),
`ifdef UART_TX_CFG_BREAK_EN
    .break_req(brk8),
`endif
    .txd(txd8), .busy(busy8));

  uart_tx_cfg #(.DATA_BITS(5), .OVERSAMPLE(OS)) dut5 (
    .clk(clk), .rst(rst), .clken(clken), .baud_strobe(baud_strobe),
    .data(data5), .valid(valid5), .ready(ready5), .parity_mode(pm5), .stop2(s2_5),
`ifdef UART_TX_CFG_BREAK_EN
    .break_req(brk5),
`endif
    .txd(txd5), .busy(busy5));

  always #5 clk = ~clk;

  bit   sel;
  logic act_ready, act_txd, act_busy, act_valid;
  always_comb begin
    act_ready = sel ? ready5 : ready8;
    act_txd   = sel ? txd5   : txd8;
    act_busy  = sel ? busy5  : busy8;
    act_valid = sel ? valid5 : valid8;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a frame is a list of line levels, each held for OS ticks.
  logic m_lv [0:15];
  bit   m_active;
  int   m_k, m_len;
  int   tick_no;
  bit   last_tick, last_acc, last_ready;
  int   strobe_pct;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void build(input int db, input logic [8:0] d, input logic [1:0] pm,
                                input logic s2);
    int   n;
    logic x;
    x = 1'b0;
    m_lv[0] = 1'b0;
    for (int i = 0; i < db; i++) begin
      m_lv[1+i] = d[i];
      x ^= d[i];
    end
    n = 1 + db;
    if (pm == 2'b01 || pm == 2'b10) begin
      m_lv[n] = (pm == 2'b10) ? x : ~x;
      n++;
    end
    m_lv[n] = 1'b1;
    n++;
    if (s2) begin
      m_lv[n] = 1'b1;
      n++;
    end
    m_len = n * OS;
  endfunction

  task automatic set_in(input logic [8:0] d, input logic [1:0] pm, input logic s2, input logic v);
    if (sel) begin
      data5 = d[4:0]; pm5 = pm; s2_5 = s2; valid5 = v; valid8 = 1'b0;
    end else begin
      data8 = d[7:0]; pm8 = pm; s2_8 = s2; valid8 = v; valid5 = 1'b0;
    end
  endtask

  task automatic drive_rand();
    @(negedge clk);
    baud_strobe = ($urandom_range(0, 99) < strobe_pct);
    clken       = ($urandom_range(0, 9) != 0);
    #1;
  endtask

  task automatic cyc();
    bit         tk, er, acc;
    logic [8:0] d;
    logic [1:0] pm;
    logic       s2;
    drive_rand();
    tk = clken && baud_strobe;
    er = tk && (!m_active || (m_k + 1 == m_len));
    chk("ready", act_ready, er);
    last_ready = act_ready;
    acc = er && act_valid;
    d   = sel ? {4'b0, data5} : {1'b0, data8};
    pm  = sel ? pm5 : pm8;
    s2  = sel ? s2_5 : s2_8;
    @(posedge clk);
    #1;
    if (tk) begin
      tick_no++;
      if (acc) begin
        build(sel ? 5 : 8, d, pm, s2);
        m_active = 1'b1;
        m_k = 0;
      end else if (m_active) begin
        if (m_k + 1 == m_len) m_active = 1'b0;
        else m_k++;
      end
    end
    last_tick = tk;
    last_acc  = acc;
    chk("txd", act_txd, m_active ? m_lv[m_k / OS] : 1'b1);
    chk("busy", act_busy, m_active);
  endtask

  task automatic wait_accept(input string tag);
    int cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (!last_acc && cnt < 500);
    if (!last_acc) chk({tag, "_accept_timeout"}, 0, 1);
  endtask

  task automatic drain();
    int cnt = 0;
    while (m_active && cnt < 5000) begin
      cyc();
      cnt++;
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int   cnt, ticks, db;
    logic par_seen;
    sel = v.sel;
    db  = v.sel ? 5 : 8;
    set_in(v.data, v.pm, v.s2, 1'b1);
    wait_accept(tag);
    if (v.scramble) set_in(~v.data, 2'b10, ~v.s2, 1'b0);
    else            set_in(v.data, v.pm, v.s2, 1'b0);
    ticks = 0;
    cnt = 0;
    par_seen = 1'bx;
    while (act_busy && cnt < 5000) begin
      cyc();
      cnt++;
      if (last_tick) ticks++;
      if (m_active && (m_k / OS == 1 + db) && (v.pm == 2'b01 || v.pm == 2'b10)) par_seen = act_txd;
    end
    chk({tag, "_len"}, ticks, v.exp_len);
    if (v.exp_par >= 0) chk({tag, "_par"}, par_seen, v.exp_par[0]);
    drain();
  endtask

  vec_t tbl [0:6];

  initial begin
    int   cnt, t0, tks;
    bit   held;
    vec_t rv;

    tbl[0] = '{1'b0, 9'h0A5, 2'b00, 1'b0, 1'b0, 40, -1};
    tbl[1] = '{1'b0, 9'h007, 2'b10, 1'b0, 1'b0, 44,  1};
    tbl[2] = '{1'b0, 9'h007, 2'b01, 1'b0, 1'b0, 44,  0};
    tbl[3] = '{1'b0, 9'h03C, 2'b11, 1'b1, 1'b0, 44, -1};
    tbl[4] = '{1'b1, 9'h01F, 2'b00, 1'b0, 1'b1, 28, -1};
    tbl[5] = '{1'b1, 9'h00A, 2'b10, 1'b1, 1'b0, 36,  0};
    tbl[6] = '{1'b0, 9'h080, 2'b01, 1'b1, 1'b0, 48,  0};

    rst = 1'b1; clken = 1'b0; baud_strobe = 1'b0;
    data8 = '0; pm8 = '0; s2_8 = 1'b0; valid8 = 1'b0;
    data5 = '0; pm5 = '0; s2_5 = 1'b0; valid5 = 1'b0;
`ifdef UART_TX_CFG_BREAK_EN
    brk8 = 1'b0; brk5 = 1'b0;
`endif
    sel = 1'b0; m_active = 1'b0; m_k = 0; m_len = 0; tick_no = 0;
    last_tick = 1'b0; last_acc = 1'b0; last_ready = 1'b0; strobe_pct = 50;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd8", txd8, 1'b1);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_ready8", ready8, 1'b0);
    chk("rst_txd5", txd5, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run_frame(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back frames with two stop bits and valid held high.
    sel = 1'b0;
    strobe_pct = 60;
    set_in(9'h000, 2'b00, 1'b1, 1'b1);
    wait_accept("b2b_first");
    t0 = tick_no;
    set_in(9'h0FF, 2'b00, 1'b1, 1'b1);
    held = 1'b1;
    cnt = 0;
    do begin
      cyc();
      cnt++;
      if (!act_busy) held = 1'b0;
    end while (!last_acc && cnt < 500);
    chk("b2b_gap", tick_no - t0, 44);
    chk("b2b_busy_held", held, 1'b1);
    set_in(9'h0FF, 2'b00, 1'b1, 1'b0);
    drain();

    // Reset during data bit 3.
    set_in(9'h0A5, 2'b00, 1'b0, 1'b1);
    wait_accept("rst_mid");
    set_in(9'h0A5, 2'b00, 1'b0, 1'b0);
    cnt = 0;
    while (!(m_active && m_k / OS == 4) && cnt < 500) begin
      cyc();
      cnt++;
    end
    chk("rst_mid_reached", m_k / OS, 4);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_txd", txd8, 1'b1);
    chk("rst_mid_busy", busy8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_active = 1'b0;
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (!last_tick && cnt < 500);
    chk("ready_after_rst", last_ready, 1'b1);

`ifdef UART_TX_CFG_BREAK_EN
    sel = 1'b0;
    set_in(9'h055, 2'b00, 1'b0, 1'b0);
    brk8 = 1'b1;
    tks = 0;
    cnt = 0;
    while (tks < 20 && cnt < 1000) begin
      drive_rand();
      chk("brk_ready", ready8, 1'b0);
      @(posedge clk);
      #1;
      chk("brk_txd", txd8, 1'b0);
      if (clken && baud_strobe) tks++;
      cnt++;
    end
    @(negedge clk);
    brk8 = 1'b0;
    tks = 0;
    cnt = 0;
    do begin
      drive_rand();
      chk("brk_mark_txd", txd8, 1'b1);
      if (ready8) break;
      @(posedge clk);
      #1;
      if (clken && baud_strobe) tks++;
      cnt++;
    end while (cnt < 1000);
    chk("brk_mark_ticks", tks >= OS, 1'b1);
`endif

    // Random frames across both instances.
    for (int i = 0; i < 20; i++) begin
      rv.sel      = $urandom_range(0, 1);
      rv.data     = 9'($urandom_range(0, 255));
      rv.pm       = 2'($urandom_range(0, 3));
      rv.s2       = $urandom_range(0, 1);
      rv.scramble = $urandom_range(0, 1);
      rv.exp_len  = (1 + (rv.sel ? 5 : 8) + ((rv.pm == 2'b01 || rv.pm == 2'b10) ? 1 : 0)
                    + (rv.s2 ? 2 : 1)) * OS;
      rv.exp_par  = -1;
      strobe_pct  = $urandom_range(25, 100);
      run_frame(rv, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised successor to the fixed 8N1 UART transmitter.
- Serialises one word per valid/ready handshake onto txd at one bit per OVERSAMPLE baud strobes.
- Adds configurable data width, runtime parity (none/odd/even), runtime 1 or 2 stop bits, back-to-back frames with no idle gap, and a busy flag.
- Sits between a byte-stream source (FIFO or USB endpoint) and the pad driver; the baud strobe comes from the shared baud generator.

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..9; LSB sent first.
- OVERSAMPLE, 16: baud strobes per bit; legal range 2..64.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- clken  in  1  global clock enable; when low, no state changes
- baud_strobe  in  1  one-clk pulse at OVERSAMPLE x baud rate
- data  in  DATA_BITS  word to send
- valid  in  1  data valid
- ready  out  1  combinational; a transfer occurs on a clk edge where valid && ready
- parity_mode  in  2  00 none, 01 odd, 10 even, 11 treated as none
- stop2  in  1  1 = two stop bits, 0 = one stop bit
- txd  out  1  serial output, idle high
- busy  out  1  high from acceptance until the final stop bit ends with no new word accepted

Behaviour:
- Reset (async): txd=1, busy=0, state=IDLE, all counters 0.
- States and transitions:
  - IDLE -> START on accept.
  - START -> DATA.
  - DATA -> PARITY if parity enabled, else STOP.
  - PARITY -> STOP.
  - STOP -> IDLE, or -> START if a word is accepted.
- Tick: a clk edge with clken && baud_strobe. Nothing advances on other edges.
- ready = clken && baud_strobe && (state==IDLE || (state==STOP && last stop bit && tick_cnt==0)).
- On accept:
  - Latch data, parity_mode and stop2.
  - txd=0 on that same edge; tick_cnt=OVERSAMPLE-1; state=START; busy=1.
  - Inputs changing mid-frame have no effect.
- Bit timing: tick_cnt decrements each tick. On the tick where tick_cnt==0, the next bit is driven and tick_cnt reloads to OVERSAMPLE-1. Every bit lasts exactly OVERSAMPLE ticks.
- DATA phase: bit_cnt counts DATA_BITS bits; txd = shift_reg[0]; shift right.
- Parity bit value:
  - even: XOR of the latched data.
  - odd: the inverse of that XOR.
- STOP phase: txd=1 for 1 or 2 bit periods per the latched stop2.
- End of frame, at the final stop tick_cnt==0 tick:
  - valid high: new frame starts on that edge with no gap; busy stays 1.
  - valid low: state=IDLE, busy=0, txd stays 1.
- Frame length: (1 + DATA_BITS + P + S) * OVERSAMPLE ticks, where P = 1 if parity is enabled else 0, and S = 1 or 2.
- valid may be held indefinitely; no transfer occurs without a tick.
- Reset mid-frame: txd returns to 1 immediately; the frame is abandoned.

Optional Feature:
- Macro: UART_TX_CFG_BREAK_EN.
- Defined:
  - Adds input port break_req (1 bit).
  - While break_req=1 and state==IDLE, txd=0 and ready=0.
  - A break_req asserted mid-frame takes effect only after the frame's final stop bit.
  - On deassertion, txd=1 for at least one full bit period (OVERSAMPLE ticks) before ready can assert.
- Undefined: no break_req port; behaviour as above.

Decomposition:
- Shared package uart_pkg holds:
  - parity_mode encodings (PAR_NONE, PAR_ODD, PAR_EVEN).
  - the tx state typedef (IDLE, START, DATA, PARITY, STOP).
  - a parity function.
  - the receiver reuses the package later.
- No sub-module: the tick counter and the bit counter are trivial inline logic.

Test Plan:
- DATA_BITS=8, OVERSAMPLE=4, parity none, stop2=0; send 0xA5 -> txd: 0,1,0,1,0,0,1,0,1,1, each level held 4 ticks; busy low after 40 ticks; ready seen only on ticks.
- parity_mode=10, data 0x07 -> parity bit 1; parity_mode=01, same data -> parity bit 0; frame length 44 ticks.
- stop2=1 with valid held high across two words 0x00 and 0xFF -> stop level lasts 8 ticks, next start bit begins on the same edge as the stop end, busy never drops.
- DATA_BITS=5; send 0x1F, change data/parity_mode mid-frame -> frame matches the latched values only; 7 bits x OVERSAMPLE ticks.
- Assert rst during DATA bit 3 -> txd=1 and busy=0 asynchronously; ready on the next tick after release.
- With UART_TX_CFG_BREAK_EN: break_req=1 for 20 ticks while idle -> txd=0 and ready=0 throughout; after release, txd=1 for 4 ticks before ready asserts.
